// File: rtl/gray_pkg.sv
// Shared Gray-code definitions: tracker FSM encodings, default width and the
// binary-to-Gray encoder used by Gray sources and test stimulus.
package gray_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  // Encoder sized for the widest legal code; callers take the low WIDTH bits.
  function automatic logic [15:0] bin2gray(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Purely combinational reflected-binary Gray to binary conversion (XOR chain
// from the MSB down); zero latency, no flow control.
module gray2bin #(
  parameter int WIDTH = gray_pkg::DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = '0;
    bin[WIDTH-1] = gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/gray_tracker.sv
// Tracks a Gray-coded position: converts samples, flags +/-1 steps, counts wraps
// and latches illegal jumps. 1-cycle latency; no backpressure, every sample accepted.
module gray_tracker
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clr_err,
  output logic             out_valid,
  output logic [WIDTH-1:0] bin_out,
  output logic             dir_up,
  output logic             dir_dn,
  output logic             err,
  output logic [3:0]       rev_cnt
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ONES = '1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] bin_new;
  logic [WIDTH-1:0] delta;
  logic             out_valid_nxt, dir_up_nxt, dir_dn_nxt, err_nxt;
  logic [WIDTH-1:0] bin_nxt;
  logic [3:0]       rev_nxt;

  gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
    .gray (gray_in),
    .bin  (bin_new)
  );

  // bin_out doubles as the stored reference sample.
  assign delta = bin_new - bin_out;

  always_comb begin
    state_nxt     = state;
    out_valid_nxt = 1'b0;
    dir_up_nxt    = 1'b0;
    dir_dn_nxt    = 1'b0;
    err_nxt       = err;
    bin_nxt       = bin_out;
    rev_nxt       = rev_cnt;

    unique case (state)
      EMPTY: begin
        if (in_valid) begin
          out_valid_nxt = 1'b1;
          bin_nxt       = bin_new;
          state_nxt     = TRACK;
        end
      end
      TRACK: begin
        if (in_valid) begin
          out_valid_nxt = 1'b1;
          bin_nxt       = bin_new;
          if (delta == ONE) begin
            dir_up_nxt = 1'b1;
            if (bin_out == ONES) rev_nxt = rev_cnt + 4'd1;
          end else if (delta == ONES) begin
            dir_dn_nxt = 1'b1;
            if (bin_out == '0) rev_nxt = rev_cnt - 4'd1;
          end else if (delta != '0) begin
            err_nxt   = 1'b1;
            state_nxt = FAULT;
          end
        end
      end
      FAULT: begin
        // A coincident sample is still taken as the new reference, unchecked.
        if (clr_err) begin
          err_nxt   = 1'b0;
          state_nxt = TRACK;
        end
        if (in_valid) begin
          out_valid_nxt = 1'b1;
          bin_nxt       = bin_new;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      bin_out   <= '0;
      dir_up    <= 1'b0;
      dir_dn    <= 1'b0;
      err       <= 1'b0;
      rev_cnt   <= 4'd0;
    end else begin
      state     <= state_nxt;
      out_valid <= out_valid_nxt;
      bin_out   <= bin_nxt;
      dir_up    <= dir_up_nxt;
      dir_dn    <= dir_dn_nxt;
      err       <= err_nxt;
      rev_cnt   <= rev_nxt;
    end
  end

endmodule

// File: tb/tb_gray_tracker.sv
// Scenario bench for gray_tracker (WIDTH=4): expected outputs are queued as each
// cycle of stimulus is driven and compared when the registered outputs appear.
module tb_gray_tracker;
  import gray_pkg::*;

  typedef struct packed {
    logic       ov;
    logic [3:0] bin;
    logic       up;
    logic       dn;
    logic       err;
    logic [3:0] rev;
  } obs_t;

  typedef struct packed {
    logic       rst_n;
    logic       v;
    logic       c;
    logic [3:0] g;
    obs_t       e;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] gray_in = 4'd0;
  logic       clr_err = 1'b0;
  logic       out_valid;
  logic [3:0] bin_out;
  logic       dir_up;
  logic       dir_dn;
  logic       err;
  logic [3:0] rev_cnt;

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t exp_q[$];
  obs_t obs, e;

  gray_tracker #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .gray_in   (gray_in),
    .clr_err   (clr_err),
    .out_valid (out_valid),
    .bin_out   (bin_out),
    .dir_up    (dir_up),
    .dir_dn    (dir_dn),
    .err       (err),
    .rev_cnt   (rev_cnt)
  );

  always #5 clk = ~clk;

  function automatic stim_t S(input int r, input int v, input int c, input int g,
                              input int ov, input int bin, input int up,
                              input int dn, input int er, input int rev);
    stim_t s;
    s.rst_n = r[0];
    s.v     = v[0];
    s.c     = c[0];
    s.g     = g[3:0];
    s.e     = '{ov[0], bin[3:0], up[0], dn[0], er[0], rev[3:0]};
    return s;
  endfunction

  // Drives one cycle from a negedge, queues its expectation, returns at the next negedge.
  task automatic apply(input stim_t s);
    rst_n    = s.rst_n;
    in_valid = s.v;
    clr_err  = s.c;
    gray_in  = s.g;
    exp_q.push_back(s.e);
    @(negedge clk);
    obs = '{out_valid, bin_out, dir_up, dir_dn, err, rev_cnt};
  endtask

  task automatic test_reset();
    stim_t t[$];
    t.push_back(S(0, 1, 1, 4'b0110, 0, 0, 0, 0, 0, 0));
    t.push_back(S(0, 1, 0, 4'b1011, 0, 0, 0, 0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset[%0d] got ov/bin/up/dn/err/rev=%b/%0d/%b/%b/%b/%0d exp %b/%0d/%b/%b/%b/%0d",
                 i, obs.ov, obs.bin, obs.up, obs.dn, obs.err, obs.rev, e.ov, e.bin, e.up, e.dn, e.err, e.rev);
      end
    end
  endtask

  task automatic test_count_up();
    stim_t t[$];
    t.push_back(S(1, 1, 0, 4'b0000, 1, 0, 0, 0, 0, 0));
    t.push_back(S(1, 1, 0, 4'b0001, 1, 1, 1, 0, 0, 0));
    t.push_back(S(1, 1, 0, 4'b0011, 1, 2, 1, 0, 0, 0));
    t.push_back(S(1, 1, 0, 4'b0010, 1, 3, 1, 0, 0, 0));
    t.push_back(S(1, 0, 0, 4'b1111, 0, 3, 0, 0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL count_up[%0d] got ov/bin/up/dn/err/rev=%b/%0d/%b/%b/%b/%0d exp %b/%0d/%b/%b/%b/%0d",
                 i, obs.ov, obs.bin, obs.up, obs.dn, obs.err, obs.rev, e.ov, e.bin, e.up, e.dn, e.err, e.rev);
      end
    end
  endtask

  task automatic test_wrap();
    stim_t t[$];
    t.push_back(S(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
    t.push_back(S(1, 1, 0, 4'b1000, 1, 15, 0, 0, 0, 0));
    t.push_back(S(1, 1, 0, 4'b0000, 1, 0, 1, 0, 0, 1));
    t.push_back(S(1, 1, 0, 4'b1000, 1, 15, 0, 1, 0, 0));
    t.push_back(S(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
    t.push_back(S(1, 1, 0, 4'b0000, 1, 0, 0, 0, 0, 0));
    t.push_back(S(1, 1, 0, 4'b1000, 1, 15, 0, 1, 0, 15));
    t.push_back(S(1, 1, 0, 4'b0000, 1, 0, 1, 0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL wrap[%0d] got ov/bin/up/dn/err/rev=%b/%0d/%b/%b/%b/%0d exp %b/%0d/%b/%b/%b/%0d",
                 i, obs.ov, obs.bin, obs.up, obs.dn, obs.err, obs.rev, e.ov, e.bin, e.up, e.dn, e.err, e.rev);
      end
    end
  endtask

  task automatic test_fault();
    stim_t t[$];
    t.push_back(S(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
    t.push_back(S(1, 1, 0, 4'b0001, 1, 1, 0, 0, 0, 0));
    t.push_back(S(1, 1, 0, 4'b1001, 1, 14, 0, 0, 1, 0));
    t.push_back(S(1, 1, 0, 4'b1011, 1, 13, 0, 0, 1, 0));
    t.push_back(S(1, 1, 0, 4'b1001, 1, 14, 0, 0, 1, 0));
    t.push_back(S(1, 1, 0, 4'b1011, 1, 13, 0, 0, 1, 0));
    t.push_back(S(1, 0, 0, 4'b0000, 0, 13, 0, 0, 1, 0));
    t.push_back(S(1, 0, 1, 4'b0000, 0, 13, 0, 0, 0, 0));
    t.push_back(S(1, 1, 0, 4'b1010, 1, 12, 0, 1, 0, 0));
    t.push_back(S(1, 0, 1, 4'b0000, 0, 12, 0, 0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL fault[%0d] got ov/bin/up/dn/err/rev=%b/%0d/%b/%b/%b/%0d exp %b/%0d/%b/%b/%b/%0d",
                 i, obs.ov, obs.bin, obs.up, obs.dn, obs.err, obs.rev, e.ov, e.bin, e.up, e.dn, e.err, e.rev);
      end
    end
  endtask

  task automatic test_repeat();
    stim_t t[$];
    t.push_back(S(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
    t.push_back(S(1, 1, 0, 4'b0110, 1, 4, 0, 0, 0, 0));
    t.push_back(S(1, 1, 0, 4'b0110, 1, 4, 0, 0, 0, 0));
    t.push_back(S(1, 0, 0, 4'b0110, 0, 4, 0, 0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL repeat[%0d] got ov/bin/up/dn/err/rev=%b/%0d/%b/%b/%b/%0d exp %b/%0d/%b/%b/%b/%0d",
                 i, obs.ov, obs.bin, obs.up, obs.dn, obs.err, obs.rev, e.ov, e.bin, e.up, e.dn, e.err, e.rev);
      end
    end
  endtask

  // Three full upward revolutions, then a fault, a suppressed wrap and a reset.
  task automatic test_rst_fault();
    stim_t       t[$];
    logic [15:0] gw;
    t.push_back(S(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
    t.push_back(S(1, 1, 0, 4'b1000, 1, 15, 0, 0, 0, 0));
    for (int k = 0; k < 48; k++) begin
      gw = bin2gray(16'(k % 16));
      t.push_back(S(1, 1, 0, int'(gw[3:0]), 1, k % 16, 1, 0, 0, k / 16 + 1));
    end
    t.push_back(S(1, 1, 0, 4'b1011, 1, 13, 0, 0, 1, 3));
    t.push_back(S(1, 1, 0, 4'b1000, 1, 15, 0, 0, 1, 3));
    t.push_back(S(1, 1, 0, 4'b0000, 1, 0, 0, 0, 1, 3));
    t.push_back(S(0, 1, 1, 4'b1111, 0, 0, 0, 0, 0, 0));
    t.push_back(S(1, 1, 0, 4'b0101, 1, 6, 0, 0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL rst_fault[%0d] got ov/bin/up/dn/err/rev=%b/%0d/%b/%b/%b/%0d exp %b/%0d/%b/%b/%b/%0d",
                 i, obs.ov, obs.bin, obs.up, obs.dn, obs.err, obs.rev, e.ov, e.bin, e.up, e.dn, e.err, e.rev);
      end
    end
  endtask

  // Continues from bin 6 in TRACK left by test_rst_fault.
  task automatic test_clr_priority();
    stim_t t[$];
    t.push_back(S(1, 1, 0, 4'b0000, 1, 0, 0, 0, 1, 0));
    t.push_back(S(1, 1, 1, 4'b1100, 1, 8, 0, 0, 0, 0));
    t.push_back(S(1, 1, 0, 4'b1101, 1, 9, 1, 0, 0, 0));
    t.push_back(S(1, 1, 1, 4'b0010, 1, 3, 0, 0, 1, 0));
    foreach (t[i]) begin
      apply(t[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL clr_priority[%0d] got ov/bin/up/dn/err/rev=%b/%0d/%b/%b/%b/%0d exp %b/%0d/%b/%b/%b/%0d",
                 i, obs.ov, obs.bin, obs.up, obs.dn, obs.err, obs.rev, e.ov, e.bin, e.up, e.dn, e.err, e.rev);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_count_up();
    test_wrap();
    test_fault();
    test_repeat();
    test_rst_fault();
    test_clr_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_tracker.md
GRAY_TRACKER -- requirements
Module: gray_tracker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the bit width of the Gray code and the binary result (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; it is synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1, meaning gray_in is sampled this cycle.
REQ-005 The block SHALL have port gray_in, input, WIDTH, a reflected-binary Gray code sample.
REQ-006 The block SHALL have port clr_err, input, 1, meaning clear the sticky fault.
REQ-007 The block SHALL have port out_valid, output, 1, a one-cycle pulse marking new bin_out.
REQ-008 The block SHALL have port bin_out, output, WIDTH, the binary equivalent of the last accepted sample.
REQ-009 The block SHALL have port dir_up, output, 1, a pulse meaning the last step was +1 mod 2^WIDTH.
REQ-010 The block SHALL have port dir_dn, output, 1, a pulse meaning the last step was -1 mod 2^WIDTH.
REQ-011 The block SHALL have port err, output, 1, a sticky illegal-step flag.
REQ-012 The block SHALL have port rev_cnt, output, 4, a wrapping revolution counter.

Function
REQ-013 Conversion SHALL be b[WIDTH-1]=g[WIDTH-1] and b[i]=b[i+1] XOR g[i] for i = WIDTH-2 down to 0.
REQ-014 Latency SHALL be 1 cycle: in_valid at cycle N gives out_valid, bin_out, dir_up, dir_dn and err updates at N+1.
REQ-015 bin_out SHALL hold its value between accepted samples; out_valid, dir_up and dir_dn SHALL be single-cycle pulses.
REQ-016 The FSM SHALL have states EMPTY (no reference sample), TRACK and FAULT.
REQ-017 In EMPTY, in_valid SHALL load the reference, produce out_valid, assert no dir pulse, leave err unchanged, and move to TRACK.
REQ-018 In TRACK, in_valid SHALL compute delta = new_bin - prev_bin mod 2^WIDTH.
REQ-019 In TRACK, delta 0 SHALL give out_valid only.
REQ-020 In TRACK, delta +1 SHALL give dir_up.
REQ-021 In TRACK, delta -1 (all ones) SHALL give dir_dn.
REQ-022 In TRACK, any other delta SHALL set err and move to FAULT, with no dir pulse.
REQ-023 Every accepted sample SHALL become the new reference, including samples that cause a fault.
REQ-024 Wrap-around: a dir_up step from all-ones to 0 SHALL increment rev_cnt, and a dir_dn step from 0 to all-ones SHALL decrement it; rev_cnt wraps modulo 16 in both directions.
REQ-025 In FAULT, samples SHALL still be converted and produce out_valid, but dir_up, dir_dn and rev_cnt updates SHALL be suppressed.
REQ-026 clr_err in FAULT SHALL clear err the next cycle and move to TRACK.
REQ-027 When clr_err and in_valid coincide in FAULT, the clear SHALL take priority; the sample is converted and becomes the reference with no dir pulse and no fault check.
REQ-028 clr_err in EMPTY or TRACK SHALL be ignored.

Reset
REQ-029 While rst_n is low at a clk edge, the block SHALL set state EMPTY, out_valid 0, bin_out 0, dir_up 0, dir_dn 0, err 0, rev_cnt 0, and clear the stored reference.
REQ-030 Reset SHALL override in_valid and clr_err in the same cycle; mid-operation reset discards all history, so the first sample after reset is treated per REQ-017.

Structure
REQ-031 State encodings (EMPTY=2'd0, TRACK=2'd1, FAULT=2'd2) and the WIDTH default SHALL live in a shared gray_pkg include, also used by the Gray encoder.
REQ-032 The XOR-chain conversion SHALL be a purely combinational sub-module gray2bin (parameter WIDTH), instantiated once on gray_in.

Verification (WIDTH=4)
REQ-033 After reset, samples 0000,0001,0011,0010 -> bin_out 0,1,2,3; dir_up pulses on the 2nd-4th outputs; err 0.
REQ-034 Samples 1000 (bin 15) then 0000 -> dir_up, rev_cnt 0->1; then 1000 -> dir_dn, rev_cnt 1->0.
REQ-035 Samples 0001 then 1001 (bin 1 -> 14) -> err 1, state FAULT; next sample 1011 (13) -> out_valid with no dir_dn; clr_err -> err 0; following 1010 (12) -> dir_dn.
REQ-036 The same code 0110 presented twice -> two out_valid pulses, bin_out 4, no dir pulses.
REQ-037 In FAULT with rev_cnt 3, rst_n low for one cycle -> all outputs 0; next sample 0101 -> bin_out 6, no dir pulse, no err.
REQ-038 In FAULT, clr_err and in_valid with sample 1100 (bin 8) in the same cycle -> err 0, bin_out 8, no dir pulse, state TRACK.
